// File: rtl/logic_unit_pkg.sv
// rtl/logic_unit_pkg.sv - op encodings and bitwise op function for pipelined_logic_unit
package logic_unit_pkg;

    // Widest operand the shared op function handles; callers zero-extend and truncate.
    localparam int LU_MAX_W = 64;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOT  = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    // Bitwise ops are position-independent, so a caller may keep only its low WIDTH bits.
    function automatic logic [LU_MAX_W-1:0] logic_op(
        input logic [2:0]          op,
        input logic [LU_MAX_W-1:0] a,
        input logic [LU_MAX_W-1:0] b
    );
        logic [LU_MAX_W-1:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XOR:  r = a ^ b;
            OP_XNOR: r = ~(a ^ b);
            OP_NOT:  r = ~a;
            default: r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pipelined_logic_unit_skid.sv
// rtl/pipelined_logic_unit_skid.sv - generic output register plus one-entry skid stage
module lu_skid_buffer #(
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic              sk_valid;
    logic [DATA_W-1:0] sk_data;
    logic              in_fire;
    logic              or_free;

    // in_ready is a flop mirroring !sk_valid, so out_ready never reaches it combinationally.
    assign in_fire = in_valid && in_ready;
    assign or_free = !out_valid || out_ready;

    // OR refills from SK first (FIFO order), else from the input; a stalled OR diverts the beat to SK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            sk_valid  <= 1'b0;
            sk_data   <= '0;
            in_ready  <= 1'b1;
        end else if (or_free) begin
            if (sk_valid) begin
                out_valid <= 1'b1;
                out_data  <= sk_data;
                sk_valid  <= 1'b0;
                in_ready  <= 1'b1;
            end else if (in_fire) begin
                out_valid <= 1'b1;
                out_data  <= in_data;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_fire) begin
            sk_valid <= 1'b1;
            sk_data  <= in_data;
            in_ready <= 1'b0;
        end
    end

endmodule

// File: rtl/pipelined_logic_unit.sv
// rtl/pipelined_logic_unit.sv - registered eight-op bitwise unit with skid buffer and result counter
module pipelined_logic_unit
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_ones,
    output logic             y_zero,
    output logic [CNT_W-1:0] result_cnt
);

    logic [WIDTH-1:0] res;
    logic             res_ones;
    logic             res_zero;

    // Result and flags are formed at the input so they travel through the buffer together.
    always_comb begin
        res      = WIDTH'(logic_op(op, LU_MAX_W'(a), LU_MAX_W'(b)));
        res_ones = &res;
        res_zero = ~|res;
    end

    lu_skid_buffer #(
        .DATA_W (WIDTH + 2)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({res_ones, res_zero, res}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  ({y_ones, y_zero, y})
    );

    // Count accepted results, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_cnt <= '0;
        end else if (out_valid && out_ready && (result_cnt != {CNT_W{1'b1}})) begin
            result_cnt <= result_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipelined_logic_unit.sv
// tb/tb_pipelined_logic_unit.sv - self-checking bench for pipelined_logic_unit
module tb_pipelined_logic_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  op;
    logic [7:0]  a, b, y;
    logic        y_ones, y_zero;
    logic [15:0] result_cnt;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [2:0]  s_op;
    logic        s_a, s_b, s_y, s_ones, s_zero;
    logic [1:0]  s_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipelined_logic_unit #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .y_ones(y_ones), .y_zero(y_zero), .result_cnt(result_cnt)
    );

    pipelined_logic_unit #(.WIDTH(1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .op(s_op), .a(s_a), .b(s_b), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .y(s_y), .y_ones(s_ones), .y_zero(s_zero), .result_cnt(s_cnt)
    );

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
        logic       ones;
        logic       zero;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
        case (o)
            3'd0: return x & z;
            3'd1: return x | z;
            3'd2: return ~(x & z);
            3'd3: return ~(x | z);
            3'd4: return x ^ z;
            3'd5: return ~(x ^ z);
            3'd6: return ~x;
            default: return x;
        endcase
    endfunction

    initial begin
        logic [7:0] q[$];
        logic [7:0] e;
        logic [7:0] prev_y;
        logic       prev_stall;
        int         accepted, cycles;
        int         exp_cnt;
        logic       sat_y[6];

        vecs[0] = '{3'd0, 8'hF0, 8'hCC, 8'hC0, 1'b0, 1'b0};
        vecs[1] = '{3'd1, 8'hF0, 8'hCC, 8'hFC, 1'b0, 1'b0};
        vecs[2] = '{3'd2, 8'hF0, 8'hCC, 8'h3F, 1'b0, 1'b0};
        vecs[3] = '{3'd3, 8'hF0, 8'hCC, 8'h03, 1'b0, 1'b0};
        vecs[4] = '{3'd4, 8'hF0, 8'hCC, 8'h3C, 1'b0, 1'b0};
        vecs[5] = '{3'd5, 8'hF0, 8'hCC, 8'hC3, 1'b0, 1'b0};
        vecs[6] = '{3'd6, 8'hF0, 8'hCC, 8'h0F, 1'b0, 1'b0};
        vecs[7] = '{3'd7, 8'hF0, 8'hCC, 8'hF0, 1'b0, 1'b0};
        vecs[8] = '{3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0};
        vecs[9] = '{3'd4, 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b1};
        sat_y   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; op = 3'd0; a = 8'h00; b = 8'h00;
        s_in_valid = 1'b0; s_out_ready = 1'b0; s_op = 3'd0; s_a = 1'b0; s_b = 1'b0;

        // reset state
        @(negedge clk); @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_in_ready", 64'(in_ready), 1);
        chk("rst_y", 64'(y), 0);
        chk("rst_y_ones", 64'(y_ones), 0);
        chk("rst_y_zero", 64'(y_zero), 0);
        chk("rst_cnt", 64'(result_cnt), 0);
        rst_n = 1'b1;

        // table: eight ops back to back, then flag vectors
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
            chk("t1_in_ready", 64'(in_ready), 1);
            @(negedge clk);
            chk("t1_out_valid", 64'(out_valid), 1);
            chk("t1_y", 64'(y), 64'(vecs[i].y));
            chk("t1_ones", 64'(y_ones), 64'(vecs[i].ones));
            chk("t1_zero", 64'(y_zero), 64'(vecs[i].zero));
            chk("t1_cnt", 64'(result_cnt), 64'(i));
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("t1_cnt_end", 64'(result_cnt), 10);
        chk("t1_drained", 64'(out_valid), 0);
        exp_cnt = 10;

        // backpressure: two beats fill OR and SK, third stalls
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'd2; a = 8'h00; b = 8'h00;
        @(negedge clk);
        chk("t3_ready1", 64'(in_ready), 1);
        chk("t3_y1", 64'(y), 8'hFF);
        op = 3'd2; a = 8'hFF; b = 8'hFF;
        @(negedge clk);
        chk("t3_ready2", 64'(in_ready), 0);
        chk("t3_hold_y", 64'(y), 8'hFF);
        op = 3'd1; a = 8'h01; b = 8'h02;
        @(negedge clk);
        chk("t3_stall_ready", 64'(in_ready), 0);
        chk("t3_stall_y", 64'(y), 8'hFF);
        chk("t3_stall_valid", 64'(out_valid), 1);
        chk("t3_stall_ones", 64'(y_ones), 1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_out2", 64'(y), 8'h00);
        chk("t3_out2_zero", 64'(y_zero), 1);
        chk("t3_ready_back", 64'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("t3_out3", 64'(y), 8'h03);
        chk("t3_out3_valid", 64'(out_valid), 1);
        @(negedge clk);
        chk("t3_empty", 64'(out_valid), 0);
        exp_cnt += 3;
        chk("t3_cnt", 64'(result_cnt), 64'(exp_cnt));

        // random handshake toggling against a scoreboard
        accepted = 0; cycles = 0; prev_stall = 1'b0; prev_y = 8'h00;
        while ((accepted < 1000 || q.size() != 0 || out_valid) && cycles < 20000) begin
            if (cycles != 0) @(negedge clk);
            cycles++;
            if (prev_stall) begin
                chk("t4_stall_valid", 64'(out_valid), 1);
                chk("t4_stall_y", 64'(y), 64'(prev_y));
            end
            in_valid  = (accepted < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            out_ready = 1'($urandom_range(0, 1));
            op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
            if (in_valid && in_ready) begin
                q.push_back(model(op, a, b));
                accepted++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("t4_unexpected_output", 64'(y), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk("t4_y", 64'(y), 64'(e));
                    chk("t4_ones", 64'(y_ones), 64'(&e));
                    chk("t4_zero", 64'(y_zero), 64'(~|e));
                    exp_cnt++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_y = y;
        end
        if (cycles >= 20000) chk("t4_timeout", 64'(cycles), 0);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("t4_accepted", 64'(accepted), 1000);
        chk("t4_cnt", 64'(result_cnt), 64'(exp_cnt));

        // saturation on the WIDTH=1, CNT_W=2 instance; also exercises single-bit flags
        s_out_ready = 1'b1; s_a = 1'b1; s_b = 1'b0;
        for (int j = 0; j <= 6; j++) begin
            s_in_valid = (j < 6);
            s_op = 3'(j);
            @(negedge clk);
            chk("t5_cnt", 64'(s_cnt), 64'((j > 3) ? 3 : j));
            if (j < 6) begin
                chk("t5_y", 64'(s_y), 64'(sat_y[j]));
                chk("t5_ones", 64'(s_ones), 64'(sat_y[j]));
                chk("t5_zero", 64'(s_zero), 64'(!sat_y[j]));
            end
        end
        s_in_valid = 1'b0;

        // reset asserted with OR and SK both full
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'd1; a = 8'h11; b = 8'h22;
        @(negedge clk);
        op = 3'd0; a = 8'hFF; b = 8'h0F;
        @(negedge clk);
        in_valid = 1'b0;
        chk("t6_full_ready", 64'(in_ready), 0);
        chk("t6_full_y", 64'(y), 8'h33);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(out_valid), 0);
        chk("t6_rst_y", 64'(y), 0);
        chk("t6_rst_cnt", 64'(result_cnt), 0);
        chk("t6_rst_ready", 64'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; op = 3'd0; a = 8'h3C; b = 8'h0F;
        @(negedge clk);
        in_valid = 1'b0;
        chk("t6_new_valid", 64'(out_valid), 1);
        chk("t6_new_y", 64'(y), 8'h0C);
        chk("t6_new_cnt", 64'(result_cnt), 0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("t6_new_drained", 64'(out_valid), 0);
        chk("t6_new_cnt1", 64'(result_cnt), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
